seq_divider: RTL



---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 100 ++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Handshake/result bundle for the sequential divider: the requester drives
// start and operands, the divider returns status and held results.
interface seq_divider_if #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per clock, start/done handshake,
// results held from the done pulse until the next accepted start.
module seq_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic [DIVIDEND_W-1:0] q_q, quot_q;
  logic [DIVISOR_W-1:0]  r_q, d_q, rem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q, dbz_q;

  logic [DIVISOR_W:0]    r_shift;
  logic [DIVISOR_W+1:0]  diff;
  logic                  borrow;
  logic [DIVISOR_W-1:0]  r_d;
  logic [DIVIDEND_W-1:0] q_d;
  logic                  last;
  logic                  unused_diff;

  // One extra guard bit on the subtraction makes the borrow unambiguous for
  // the full (DIVISOR_W+1)-bit shifted remainder.
  always_comb begin
    r_shift = {r_q, q_q[DIVIDEND_W-1]};
    diff    = {1'b0, r_shift} - {2'b00, d_q};
    borrow  = diff[DIVISOR_W+1];
    r_d     = borrow ? r_shift[DIVISOR_W-1:0] : diff[DIVISOR_W-1:0];
    q_d     = {q_q[DIVIDEND_W-2:0], ~borrow};
  end

  // With no borrow the difference is below the divisor, so this bit is 0.
  assign unused_diff = diff[DIVISOR_W];
  assign last        = (cnt_q == CNT_W'(DIVIDEND_W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= bus.dividend[DIVISOR_W-1:0];
              dbz_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              q_q     <= bus.dividend;
              r_q     <= '0;
              d_q     <= bus.divisor;
              cnt_q   <= '0;
            end
          end
        end
        RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
